gpc1325_checker: RTL and testbench
==================================

// Module: gpc1325_checker
// PURPOSE
//  Hardware stimulus/response end for the gpc1325_5 compressor: drives the GPC
//  source columns from an LFSR and computes the expected weighted bit count
//  serially. It compares that against the GPC dst output and keeps pass/fail
//  statistics. Used for on-chip BIST of generated GPCs, paired 1:1 with a DUT.
// PARAMETERS
//  NUM_VECTORS  20      vectors applied per run (>=1)
//  SEED         11'h6C2 LFSR load value at start; 0 is replaced by 11'h001
//  CNT_W        16      width of vec_count / err_count
// PORTS
//  clk            in   1      clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      1-cycle pulse; begins a run from IDLE or DONE
//  src0           out  5      weight-1 column to DUT  (= lfsr[4:0])
//  src1           out  2      weight-2 column to DUT  (= lfsr[6:5])
//  src2           out  3      weight-4 column to DUT  (= lfsr[9:7])
//  src3           out  1      weight-8 column to DUT  (= lfsr[10])
//  dst            in   5      DUT sum output
//  busy           out  1      run in progress
//  done           out  1      run complete; held until next start or reset
//  pass           out  1      valid with done: err_count==0
//  vec_count      out  CNT_W  vectors compared so far
//  err_count      out  CNT_W  mismatching vectors; saturates at all-ones
//  first_err_vec  out  CNT_W  vec index of first mismatch
//  first_err_exp  out  5      expected sum at first mismatch
//  first_err_got  out  5      dst at first mismatch
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, lfsr=0, all outputs 0, acc=0, idx=0.
//  - src* are driven directly from the lfsr register (no comb path from dst).
//  - LFSR step: lfsr <= {lfsr[9:0], lfsr[10]^lfsr[8]} (x^11+x^9+1, maximal).
//  - FSM states: IDLE, ACCUM, COMPARE, DONE.
//  - IDLE/DONE + start: load lfsr=SEED (or 1), clear vec/err/first_err*,
//    done=0, pass=0, busy=1, acc=0, idx=0; go ACCUM.
//  - ACCUM (11 cycles, idx 0..10): acc += lfsr[idx]*w(idx); w=1 for idx 0-4,
//    2 for 5-6, 4 for 7-9, 8 for 10. acc is 5 bits; max 29, so no overflow.
//    After idx==10: go COMPARE. These cycles also give the DUT settle time.
//  - COMPARE (1 cycle): sample dst. If dst!=acc: err_count++ (saturating). If
//    this is the first error, capture first_err_vec=vec_count,
//    first_err_exp=acc and first_err_got=dst.
//    In the same cycle: vec_count++, step lfsr, acc=0, idx=0. If the new
//    vec_count==NUM_VECTORS go DONE, else ACCUM.
//  - Throughput: 12 cycles/vector; done rises 12*NUM_VECTORS cycles after the
//    start-sampling edge.
//  - DONE: busy=0, done=1, pass=(err_count==0); src* hold the last stepped value.
//  - start while busy: ignored, no effect on counters or state.
//  - start together with COMPARE->DONE: start is not honoured that cycle; DONE
//    is entered.
//  - rst_n low mid-run: immediate return to reset values; no partial results kept.
// TESTING
//  1 SEED=6C2, dst fed by correct gpc1325_5: first vector src0=02 src1=2
//    src2=5 src3=1, expected acc=0x13; after 240 cycles done=1, pass=1,
//    vec=20, err=0.
//  2 dst tied to 5'h00: first_err_vec=0, exp=0x13, got=0x00; err_count =
//    number of vectors with nonzero sum (compare against a model LFSR); pass=0.
//  3 SEED=0: lfsr loads 001 -> src0=01, others 0, expected 1; correct DUT
//    gives err=0.
//  4 CNT_W=2, NUM_VECTORS=3, DUT = correct+1: err_count reaches 3 and stays 3;
//    vec=3, pass=0.
//  5 start pulsed at cycle 50 of a run: no restart; done at cycle 240 as in
//    test 1.
//  6 rst_n=0 at cycle 100, released, then start: outputs 0 during reset;
//    new run matches test 1 exactly.

Source files
------------

// File: rtl/gpc1325_checker.sv
// BIST stimulus/response end for a gpc1325_5 compressor: LFSR-driven source
// columns, serially accumulated expected sum, and pass/fail statistics.
module gpc1325_checker #(
  parameter int unsigned NUM_VECTORS = 20,
  parameter logic [10:0] SEED        = 11'h6C2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [4:0]       src0,
  output logic [1:0]       src1,
  output logic [2:0]       src2,
  output logic             src3,
  input  logic [4:0]       dst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_vec,
  output logic [4:0]       first_err_exp,
  output logic [4:0]       first_err_got
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_DONE
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [10:0]      LOAD_VAL = (SEED == 11'h000) ? 11'h001 : SEED;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic [10:0]      lfsr_q;
  logic [4:0]       acc_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] vec_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] fvec_q;
  logic [4:0]       fexp_q;
  logic [4:0]       fgot_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [4:0]       term;
  logic [4:0]       acc_d;
  logic [10:0]      lfsr_d;
  logic [CNT_W-1:0] vec_d;
  logic [CNT_W-1:0] err_d;
  logic             mismatch;

  always_comb begin
    term = 5'd0;
    case (idx_q)
      4'd0:    term = lfsr_q[0]  ? 5'd1 : 5'd0;
      4'd1:    term = lfsr_q[1]  ? 5'd1 : 5'd0;
      4'd2:    term = lfsr_q[2]  ? 5'd1 : 5'd0;
      4'd3:    term = lfsr_q[3]  ? 5'd1 : 5'd0;
      4'd4:    term = lfsr_q[4]  ? 5'd1 : 5'd0;
      4'd5:    term = lfsr_q[5]  ? 5'd2 : 5'd0;
      4'd6:    term = lfsr_q[6]  ? 5'd2 : 5'd0;
      4'd7:    term = lfsr_q[7]  ? 5'd4 : 5'd0;
      4'd8:    term = lfsr_q[8]  ? 5'd4 : 5'd0;
      4'd9:    term = lfsr_q[9]  ? 5'd4 : 5'd0;
      4'd10:   term = lfsr_q[10] ? 5'd8 : 5'd0;
      default: term = 5'd0;
    endcase
  end

  always_comb begin
    acc_d    = acc_q + term;
    lfsr_d   = {lfsr_q[9:0], lfsr_q[10] ^ lfsr_q[8]};
    vec_d    = vec_q + CNT_ONE;
    mismatch = (dst != acc_q);
    err_d    = err_q;
    if (mismatch && (err_q != '1)) begin
      err_d = err_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_ACCUM;
            lfsr_q  <= LOAD_VAL;
            acc_q   <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fvec_q  <= '0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          if (idx_q == 4'd10) begin
            idx_q   <= '0;
            state_q <= S_COMPARE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        S_COMPARE: begin
          err_q <= err_d;
          // A zero error count before this compare marks the first mismatch.
          if (mismatch && (err_q == '0)) begin
            fvec_q <= vec_q;
            fexp_q <= acc_q;
            fgot_q <= dst;
          end
          vec_q  <= vec_d;
          lfsr_q <= lfsr_d;
          acc_q  <= '0;
          idx_q  <= '0;
          if (vec_d == LAST_VEC) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= S_ACCUM;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src0          = lfsr_q[4:0];
  assign src1          = lfsr_q[6:5];
  assign src2          = lfsr_q[9:7];
  assign src3          = lfsr_q[10];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign vec_count     = vec_q;
  assign err_count     = err_q;
  assign first_err_vec = fvec_q;
  assign first_err_exp = fexp_q;
  assign first_err_got = fgot_q;

endmodule

// File: tb/tb_gpc1325_checker.sv
// Bench for gpc1325_checker: behavioural GPC in front of each instance, a
// run-level reference model, per-cycle comparison and literal pins.
module tb_gpc1325_checker;

  localparam int          N      = 20;
  localparam logic [10:0] SEED_A = 11'h6C2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  int   mode = 0;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [4:0]  src0_a, dst_a, fexp_a, fgot_a;
  logic [1:0]  src1_a;
  logic [2:0]  src2_a;
  logic        src3_a, busy_a, done_a, pass_a;
  logic [15:0] vec_a, err_a, fvec_a;

  logic [4:0]  src0_z, dst_z, fexp_z, fgot_z;
  logic [1:0]  src1_z;
  logic [2:0]  src2_z;
  logic        src3_z, busy_z, done_z, pass_z;
  logic [15:0] vec_z, err_z, fvec_z;

  logic [4:0]  src0_s, dst_s, fexp_s, fgot_s;
  logic [1:0]  src1_s;
  logic [2:0]  src2_s;
  logic        src3_s, busy_s, done_s, pass_s;
  logic [1:0]  vec_s, err_s, fvec_s;

  always #5 clk = ~clk;

  function automatic int wsum(input logic [10:0] l);
    return $countones(l[4:0]) + 2 * $countones(l[6:5]) +
           4 * $countones(l[9:7]) + 8 * int'(l[10]);
  endfunction

  function automatic logic [10:0] lstep(input logic [10:0] l);
    return {l[9:0], l[10] ^ l[8]};
  endfunction

  // m: 0 correct compressor, 1 output stuck at zero, 2 correct plus one
  function automatic logic [4:0] gpc(input logic [10:0] l, input int m);
    int s;
    s = wsum(l);
    if (m == 1) return 5'd0;
    if (m == 2) return 5'(s + 1);
    return 5'(s);
  endfunction

  assign dst_a = gpc({src3_a, src2_a, src1_a, src0_a}, mode);
  assign dst_z = gpc({src3_z, src2_z, src1_z, src0_z}, 0);
  assign dst_s = gpc({src3_s, src2_s, src1_s, src0_s}, 2);

  gpc1325_checker u_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src0(src0_a), .src1(src1_a), .src2(src2_a), .src3(src3_a), .dst(dst_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .vec_count(vec_a), .err_count(err_a), .first_err_vec(fvec_a),
    .first_err_exp(fexp_a), .first_err_got(fgot_a)
  );

  gpc1325_checker #(.SEED(11'h000)) u_z (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src0(src0_z), .src1(src1_z), .src2(src2_z), .src3(src3_z), .dst(dst_z),
    .busy(busy_z), .done(done_z), .pass(pass_z),
    .vec_count(vec_z), .err_count(err_z), .first_err_vec(fvec_z),
    .first_err_exp(fexp_z), .first_err_got(fgot_z)
  );

  gpc1325_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src0(src0_s), .src1(src1_s), .src2(src2_s), .src3(src3_s), .dst(dst_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .vec_count(vec_s), .err_count(err_s), .first_err_vec(fvec_s),
    .first_err_exp(fexp_s), .first_err_got(fgot_s)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a run is the LFSR sequence from the seed; everything
  // visible is a function of how many edges have passed since start.
  int          m_phase = 0;
  int          m_t = 0;
  logic [10:0] m_seq [0:N];
  logic [4:0]  m_exp [0:N-1];
  logic [4:0]  m_got [0:N-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_t = 0;
    end else if (start && (m_phase == 0 || m_t >= 12 * N)) begin
      m_phase = 1;
      m_t = 0;
      m_seq[0] = SEED_A;
      for (int k = 0; k < N; k++) begin
        m_exp[k]   = 5'(wsum(m_seq[k]));
        m_got[k]   = gpc(m_seq[k], mode);
        m_seq[k+1] = lstep(m_seq[k]);
      end
    end else if (m_phase == 1 && m_t < 12 * N) begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    int          k, errs, fv;
    logic [4:0]  fe, fg;
    logic [10:0] es;
    bit          bz, dn, ps;
    if (cmp_en) begin
      k = 0; errs = 0; fv = 0; fe = 0; fg = 0; es = 0; bz = 0; dn = 0; ps = 0;
      if (m_phase == 1) begin
        k  = (m_t < 12 * N) ? m_t / 12 : N;
        es = m_seq[k];
        for (int j = 0; j < k; j++) begin
          if (m_got[j] != m_exp[j]) begin
            if (errs == 0) begin
              fv = j; fe = m_exp[j]; fg = m_got[j];
            end
            errs++;
          end
        end
        bz = (m_t < 12 * N);
        dn = !bz;
        ps = dn && (errs == 0);
      end
      chk("src",  {src3_a, src2_a, src1_a, src0_a}, es);
      chk("busy", busy_a, bz);
      chk("done", done_a, dn);
      chk("pass", pass_a, ps);
      chk("vec",  vec_a, k);
      chk("err",  err_a, errs);
      chk("fvec", fvec_a, fv);
      chk("fexp", fexp_a, fe);
      chk("fgot", fgot_a, fg);
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c;
    c = 0;
    while (!done_a && c < bound) begin
      @(posedge clk); #1;
      c++;
    end
    chk("wait_done", done_a, 1);
  endtask

  task automatic chk_first_vec_a();
    chk("v0_src0", src0_a, 5'h02);
    chk("v0_src1", src1_a, 2'h2);
    chk("v0_src2", src2_a, 3'h5);
    chk("v0_src3", src3_a, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nz;
    logic [10:0] l;

    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", busy_a, 0);
    chk("rst_src0", src0_a, 0);
    #1 rst_n = 1'b1;

    // Correct compressor: exact done latency and final literals.
    mode = 0;
    pulse_start();
    chk_first_vec_a();
    chk("z_src0", src0_z, 5'h01);
    chk("z_src_hi", {src3_z, src2_z, src1_z}, 0);
    repeat (239) @(posedge clk);
    #1 chk("t1_done_early", done_a, 0);
    @(posedge clk);
    #1 chk("t1_done", done_a, 1);
    chk("t1_pass", pass_a, 1);
    chk("t1_vec", vec_a, 20);
    chk("t1_err", err_a, 0);
    chk("z_done", done_z, 1);
    chk("z_pass", pass_z, 1);
    chk("z_err", err_z, 0);
    chk("z_vec", vec_z, 20);
    chk("s_done", done_s, 1);
    chk("s_vec", vec_s, 3);
    chk("s_err", err_s, 3);
    chk("s_pass", pass_s, 0);
    chk("s_fvec", fvec_s, 0);
    chk("s_fexp", fexp_s, 5'h13);
    chk("s_fgot", fgot_s, 5'h14);

    // Output stuck at zero.
    mode = 1;
    pulse_start();
    wait_done(300);
    nz = 0;
    l = SEED_A;
    for (int k = 0; k < N; k++) begin
      if (wsum(l) != 0) nz++;
      l = lstep(l);
    end
    chk("t2_fvec", fvec_a, 0);
    chk("t2_fexp", fexp_a, 5'h13);
    chk("t2_fgot", fgot_a, 5'h00);
    chk("t2_err", err_a, nz);
    chk("t2_pass", pass_a, 0);

    // start while busy is ignored.
    mode = 0;
    pulse_start();
    repeat (49) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (189) @(posedge clk);
    #1 chk("t5_done_early", done_a, 0);
    @(posedge clk);
    #1 chk("t5_done", done_a, 1);
    chk("t5_pass", pass_a, 1);

    // start coinciding with the final compare is not honoured.
    pulse_start();
    repeat (239) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    chk("cmp_start_done", done_a, 1);
    chk("cmp_start_busy", busy_a, 0);
    repeat (3) @(posedge clk);

    // Reset mid-run, then a fresh run.
    pulse_start();
    repeat (100) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("t6_rst_busy", busy_a, 0);
    chk("t6_rst_vec", vec_a, 0);
    chk("t6_rst_src", {src3_a, src2_a, src1_a, src0_a}, 0);
    rst_n = 1'b1;
    pulse_start();
    chk_first_vec_a();
    repeat (240) @(posedge clk);
    #1 chk("t6_done", done_a, 1);
    chk("t6_pass", pass_a, 1);
    chk("t6_vec", vec_a, 20);

    // Random runs with random start pulses.
    for (int r = 0; r < 6; r++) begin
      mode = $urandom_range(0, 2);
      pulse_start();
      for (int c = 0; c < 260; c++) begin
        @(posedge clk);
        #2 start = ($urandom_range(0, 15) == 0);
      end
      start = 1'b0;
      wait_done(300);
      repeat (2) @(posedge clk);
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
